octal_key_debouncer: RTL and testbench

Debounces and qualifies eight raw active-high key/switch lines and produces a clean one-hot `oct[7:0]` word that feeds the octal-to-binary encoder directly. The encoder is purely combinational. It is only correct for a one-hot or all-zero input. This block guarantees that input: it synchronises, arbitrates and debounces the keys, and raises a one-cycle strobe per accepted press.

---
 rtl/octal_key_debouncer.sv | 215 +++++++++++++++++++++
 tb/tb_octal_key_debouncer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octal_key_debouncer.sv
// ---------------------------------------------------------------------------
// octal_key_debouncer
//
// Turns eight raw, bouncy, asynchronous key lines into a clean one-hot word
// for the downstream combinational octal-to-binary encoder. That encoder only
// gives sane results for one-hot or all-zero input, so this block
// synchronises the keys, picks the highest pressed key, debounces both the
// press and the release, and never presents a multi-hot code.
//
// Optional feature macro: OCT_KEY_REPEAT_EN
//   defined   -> auto-repeat strobes every REPEAT_CYCLES clocks while HELD
//   undefined -> exactly one strobe per accepted press (default build)
//
// Parameters
//   DB_CYCLES     : consecutive stable samples needed to accept press/release
//   REPEAT_CYCLES : auto-repeat period in clocks (repeat build only)
//   CNT_WIDTH     : width of the debounce and repeat counters
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   key_in     : raw key lines, 1 = pressed, asynchronous to clk
//   oct        : debounced one-hot key code, 0 when no key is held
//   key_valid  : high while oct is non-zero
//   key_strobe : one-cycle pulse per accepted press (and per auto-repeat)
//   multi_err  : high while a key other than the accepted one is also down
// ---------------------------------------------------------------------------
module octal_key_debouncer #(
   parameter int DB_CYCLES     = 16,
   parameter int REPEAT_CYCLES = 256,
   parameter int CNT_WIDTH     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_in,
   output logic [7:0] oct,
   output logic       key_valid,
   output logic       key_strobe,
   output logic       multi_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DB_PRESS = 2'd1,
      HELD     = 2'd2,
      DB_REL   = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DB_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   // Parameter sanity: a debounce count below 2 or beyond the counter range
   // would make the terminal-count compare meaningless.
   if ((DB_CYCLES < 2) ||
       (longint'(DB_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1)) ||
       (REPEAT_CYCLES < 1)) begin : g_param_range_error
      $error("octal_key_debouncer: parameter out of range");
   end

   state_t               state_q, state_d;
   logic [7:0]           keyMeta_q, keySync_q;
   logic [7:0]           cand_q, cand_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]           oct_q, oct_d;
   logic                 valid_q, valid_d;
   logic                 strobe_q, strobe_d;
   logic                 multiErr_q, multiErr_d;
   logic [7:0]           pri;
   logic                 candHeld;

`ifdef OCT_KEY_REPEAT_EN
   localparam logic [CNT_WIDTH-1:0] RPT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
   logic [CNT_WIDTH-1:0] rptCnt_q, rptCnt_d;
`endif

   // Priority pick: later (higher) bits overwrite earlier ones, so the
   // highest pressed key wins and pri is always one-hot or zero.
   always_comb begin
      pri = '0;
      for (int i = 0; i < 8; i++) begin
         if (keySync_q[i]) begin
            pri    = '0;
            pri[i] = 1'b1;
         end
      end
   end

   // While a key is accepted we only watch that key's own line; other keys
   // can come and go without disturbing the code.
   assign candHeld = |(keySync_q & cand_q);

   // State register: synchroniser, FSM state, debounce bookkeeping and the
   // registered outputs. Everything clears asynchronously so the encoder sees
   // zero the moment reset is asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         keyMeta_q  <= '0;
         keySync_q  <= '0;
         state_q    <= IDLE;
         cand_q     <= '0;
         cnt_q      <= '0;
         oct_q      <= '0;
         valid_q    <= 1'b0;
         strobe_q   <= 1'b0;
         multiErr_q <= 1'b0;
`ifdef OCT_KEY_REPEAT_EN
         rptCnt_q   <= '0;
`endif
      end else begin
         keyMeta_q  <= key_in;
         keySync_q  <= keyMeta_q;
         state_q    <= state_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         oct_q      <= oct_d;
         valid_q    <= valid_d;
         strobe_q   <= strobe_d;
         multiErr_q <= multiErr_d;
`ifdef OCT_KEY_REPEAT_EN
         rptCnt_q   <= rptCnt_d;
`endif
      end
   end

   // Next-state logic. Press debounce tracks a candidate key and restarts
   // whenever the winning key changes; release debounce restarts whenever
   // the accepted key's line comes back, which absorbs release bounce.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pri != 8'h00) begin
               cand_d  = pri;
               cnt_d   = '0;
               state_d = DB_PRESS;
            end
         end
         DB_PRESS: begin
            if (pri == 8'h00) begin
               state_d = IDLE;
            end else if (pri != cand_q) begin
               cand_d = pri;
               cnt_d  = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!candHeld) begin
               state_d = DB_REL;
               cnt_d   = '0;
            end
         end
         DB_REL: begin
            if (candHeld) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic. The code is loaded only on the DB_PRESS->HELD transition
   // and cleared only on DB_REL->IDLE, so oct is a copy of the one-hot
   // candidate or zero. multi_err looks at the state before the edge.
   always_comb begin
      oct_d      = oct_q;
      valid_d    = valid_q;
      strobe_d   = 1'b0;
      multiErr_d = ((state_q == HELD) || (state_q == DB_REL)) &&
                   ((keySync_q & ~cand_q) != 8'h00);
      if ((state_q == DB_PRESS) && (state_d == HELD)) begin
         oct_d    = cand_q;
         valid_d  = 1'b1;
         strobe_d = 1'b1;
      end
      if ((state_q == DB_REL) && (state_d == IDLE)) begin
         oct_d   = '0;
         valid_d = 1'b0;
      end
`ifdef OCT_KEY_REPEAT_EN
      // Repeat timer restarts on every entry to HELD, runs while in HELD and
      // freezes during release debounce.
      rptCnt_d = rptCnt_q;
      if ((state_d == HELD) && (state_q != HELD)) begin
         rptCnt_d = '0;
      end else if (state_q == HELD) begin
         if (rptCnt_q == RPT_LAST) begin
            rptCnt_d = '0;
            strobe_d = 1'b1;
         end else begin
            rptCnt_d = rptCnt_q + CNT_ONE;
         end
      end
`endif
   end

   assign oct        = oct_q;
   assign key_valid  = valid_q;
   assign key_strobe = strobe_q;
   assign multi_err  = multiErr_q;

endmodule

// File: tb/tb_octal_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_octal_key_debouncer
//
// Drives octal_key_debouncer with DB_CYCLES = 4 and REPEAT_CYCLES = 10.
// A vector table covers a clean press/release, hand-written sequences cover
// bounce, simultaneous keys, release glitch, reset while held and the
// strobe count, and a random phase is compared against a run-length model.
// ---------------------------------------------------------------------------
module tb_octal_key_debouncer;

   localparam int DB  = 4;
   localparam int RPT = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key_in;
   logic [7:0] oct;
   logic       key_valid;
   logic       key_strobe;
   logic       multi_err;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model state: a two-deep input history, whether a key is
   // currently accepted, and run lengths of identical samples.
   logic [7:0] mMeta, mSync, mAcc, mRunKey;
   logic       mHolding, mStrobe, mMulti;
   int         mRunLen, mAbsRun, mHeldCnt;

   typedef struct packed {
      logic [7:0] key;
      logic [7:0] expOct;
      logic       expValid;
      logic       expStrobe;
      logic       expMulti;
   } vec_t;

   vec_t cleanVec [28];

   octal_key_debouncer #(
      .DB_CYCLES    (DB),
      .REPEAT_CYCLES(RPT),
      .CNT_WIDTH    (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .oct       (oct),
      .key_valid (key_valid),
      .key_strobe(key_strobe),
      .multi_err (multi_err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   function automatic logic [10:0] outs();
      return {oct, key_valid, key_strobe, multi_err};
   endfunction

   function automatic logic [10:0] ex(input logic [7:0] o, input logic v,
                                      input logic s, input logic m);
      return {o, v, s, m};
   endfunction

   function automatic int encode(input logic [7:0] o);
      int idx;
      idx = 0;
      for (int i = 0; i < 8; i++) if (o[i]) idx = i;
      return idx;
   endfunction

   task automatic modelReset();
      mMeta    = '0;
      mSync    = '0;
      mAcc     = '0;
      mRunKey  = '0;
      mHolding = 1'b0;
      mStrobe  = 1'b0;
      mMulti   = 1'b0;
      mRunLen  = 0;
      mAbsRun  = 0;
      mHeldCnt = 0;
   endtask

   // One clock edge of the model: a press is accepted once the same winning
   // key has been seen on DB+1 consecutive edges; a release completes once
   // the accepted key has been absent on DB+1 consecutive edges.
   task automatic modelStep();
      logic [7:0] ks, pri;
      logic       wasHolding;
      ks    = mSync;
      mSync = mMeta;
      mMeta = key_in;
      pri   = '0;
      for (int i = 7; i >= 0; i--) begin
         if (ks[i]) begin
            pri = 8'h01 << i;
            break;
         end
      end
      wasHolding = mHolding;
      mMulti     = wasHolding && ((ks & ~mAcc) != 8'h00);
      mStrobe    = 1'b0;
      if (!wasHolding) begin
         if ((pri != 8'h00) && (pri == mRunKey)) mRunLen++;
         else begin
            mRunKey = pri;
            mRunLen = (pri != 8'h00) ? 1 : 0;
         end
         if (mRunLen == DB + 1) begin
            mHolding = 1'b1;
            mAcc     = pri;
            mStrobe  = 1'b1;
            mAbsRun  = 0;
            mHeldCnt = 0;
         end
      end else begin
`ifdef OCT_KEY_REPEAT_EN
         if (mAbsRun == 0) begin
            if (mHeldCnt == RPT - 1) begin
               mStrobe  = 1'b1;
               mHeldCnt = 0;
            end else mHeldCnt++;
         end
`endif
         if ((ks & mAcc) != 8'h00) begin
            if (mAbsRun != 0) mHeldCnt = 0;
            mAbsRun = 0;
         end else begin
            mAbsRun++;
            if (mAbsRun == DB + 1) begin
               mHolding = 1'b0;
               mAcc     = '0;
               mRunKey  = '0;
               mRunLen  = 0;
            end
         end
      end
   endtask

   function automatic logic [10:0] modelOuts();
      return {(mHolding ? mAcc : 8'h00), mHolding, mStrobe, mMulti};
   endfunction

   task automatic applyStimulus(input logic [7:0] k);
      key_in = k;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) modelReset();
      else modelStep();
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [10:0] act,
                              input logic [10:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got oct=%h valid=%b strobe=%b multi=%b, expected oct=%h valid=%b strobe=%b multi=%b",
                  name, act[10:3], act[2], act[1], act[0],
                  exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic checkCount(input string name, input int act, input int exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Main sequence: table, directed corner cases, then random vs model.
   initial begin
      int strobes;
      logic [7:0] cur;
      int r;

      // Clean press of key 3 held for 20 edges, then released for 8 edges.
      for (int i = 0; i < 28; i++) begin
         cleanVec[i].key       = (i < 20) ? 8'h08 : 8'h00;
         cleanVec[i].expValid  = (i + 1 >= 7) && (i + 1 <= 26);
         cleanVec[i].expOct    = cleanVec[i].expValid ? 8'h08 : 8'h00;
`ifdef OCT_KEY_REPEAT_EN
         cleanVec[i].expStrobe = (i + 1 == 7) || (i + 1 == 17);
`else
         cleanVec[i].expStrobe = (i + 1 == 7);
`endif
         cleanVec[i].expMulti  = 1'b0;
      end

      rst = 1'b1;
      applyStimulus(8'h00);
      modelReset();
      #1;
      checkOutput("reset_state", outs(), ex(8'h00, 0, 0, 0));
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 28; i++) begin
         applyStimulus(cleanVec[i].key);
         tick();
         checkOutput($sformatf("clean[%0d]", i), outs(),
                     ex(cleanVec[i].expOct, cleanVec[i].expValid,
                        cleanVec[i].expStrobe, cleanVec[i].expMulti));
         if (i == 19) checkCount("encoder_out", encode(oct), 3);
      end

      // Bounce: toggle key 5 every two edges, then settle.
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < 4; k++) begin
            applyStimulus((k < 2) ? 8'h20 : 8'h00);
            tick();
            checkOutput("bounce_toggle", outs(), ex(8'h00, 0, 0, 0));
         end
      end
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(8'h20);
         tick();
         if (k < 7) checkOutput("bounce_settle_wait", outs(), ex(8'h00, 0, 0, 0));
         else checkOutput("bounce_settle_accept", outs(), ex(8'h20, 1, (k == 7), 0));
      end
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(8'h00);
         tick();
         if (k == 6) checkOutput("bounce_rel_hold", outs(), ex(8'h20, 1, 0, 0));
         if (k == 7) checkOutput("bounce_rel_done", outs(), ex(8'h00, 0, 0, 0));
      end

      // Simultaneous keys 7 and 0: key 7 wins, key 0 raises multi_err.
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(8'h81);
         tick();
         if (k == 6) checkOutput("simul_wait", outs(), ex(8'h00, 0, 0, 0));
         if (k == 7) checkOutput("simul_accept", outs(), ex(8'h80, 1, 1, 0));
         if (k == 8) checkOutput("simul_multi", outs(), ex(8'h80, 1, 0, 1));
      end
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(8'h01);
         tick();
         if (k == 6)  checkOutput("simul_rel_hold", outs(), ex(8'h80, 1, 0, 1));
         if (k == 7)  checkOutput("simul_rel_done", outs(), ex(8'h00, 0, 0, 1));
         if (k == 8)  checkOutput("simul_idle", outs(), ex(8'h00, 0, 0, 0));
         if (k == 11) checkOutput("simul_repress_wait", outs(), ex(8'h00, 0, 0, 0));
         if (k == 12) checkOutput("simul_repress", outs(), ex(8'h01, 1, 1, 0));
      end

      // Release glitch: drop key 0 for two edges while held.
      for (int k = 0; k < 13; k++) begin
         applyStimulus((k == 3 || k == 4) ? 8'h00 : 8'h01);
         tick();
         checkOutput("glitch_hold", outs(), ex(8'h01, 1, 0, 0));
      end
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'h00);
         tick();
      end
      checkOutput("glitch_released", outs(), ex(8'h00, 0, 0, 0));

      // Reset while key 2 is held: immediate clear, then a fresh press.
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(8'h04);
         tick();
         if (k == 7) checkOutput("rst_pre_accept", outs(), ex(8'h04, 1, 1, 0));
      end
      rst = 1'b1;
      #1;
      checkOutput("rst_async_clear", outs(), ex(8'h00, 0, 0, 0));
      tick();
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k < 7) checkOutput("rst_repress_wait", outs(), ex(8'h00, 0, 0, 0));
         else checkOutput("rst_repress", outs(), ex(8'h04, 1, 1, 0));
      end

      // Strobe count for key 1 held through acceptance plus 40 edges.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'h00);
         tick();
      end
      strobes = 0;
      for (int k = 1; k <= 47; k++) begin
         applyStimulus(8'h02);
         tick();
         if (key_strobe) strobes++;
      end
`ifdef OCT_KEY_REPEAT_EN
      checkCount("strobe_count", strobes, 5);
`else
      checkCount("strobe_count", strobes, 1);
`endif

      // Random stimulus against the model, with one reset mid-run.
      cur = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            rst = 1'b1;
            #1;
            checkOutput("random_rst", outs(), ex(8'h00, 0, 0, 0));
            tick();
            rst = 1'b0;
         end
         r = $urandom_range(0, 15);
         if (r == 0) cur = 8'h00;
         else if (r == 1) cur = 8'($urandom);
         else if (r == 2) cur = 8'h01 << $urandom_range(0, 7);
         else if (r == 3) cur = cur ^ (8'h01 << $urandom_range(0, 7));
         applyStimulus(cur);
         tick();
         checkOutput("random", outs(), modelOuts());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
